// File: rtl/fp32_to_int_conv.sv
// fp32_to_int_conv: multi-cycle IEEE754 single-precision to signed int32 converter.
// Valid/ready handshake on both sides. Alignment uses an iterative shifter that moves
// SHIFT_PER_CYCLE bit positions per ALIGN cycle.
// Build option: define FP2INT_RNE_EN for round-to-nearest-even; the default build
// rounds toward zero (truncates). Latency is the same in both builds.
module fp32_to_int_conv #(
    parameter int SHIFT_PER_CYCLE = 4   // legal range 1..8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    localparam logic [5:0]  SPC     = 6'(SHIFT_PER_CYCLE);
    localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;

    state_t      state_q;
    logic        sign_q;
    logic        left_q;      // shift direction: 1 = left (e > 23)
    logic [5:0]  rem_q;       // bit positions still to shift
    logic [55:0] w_q;         // alignment window, integer magnitude in the low bits
    logic        guard_q;
    logic        sticky_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [2:0]  out_flags_q;

    // Operand field decode (only meaningful in IDLE)
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic [5:0]  in_n;
    logic        in_mant_nz;

    // Operand decode: n = |exp - 150| = |e - 23|, only used for exponents that align
    always_comb begin
        in_sign    = in_data[31];
        in_exp     = in_data[30:23];
        in_mant    = in_data[22:0];
        in_mant_nz = |in_mant;
        in_n       = (in_exp > 8'd150) ? 6'(in_exp - 8'd150) : 6'(8'd150 - in_exp);
    end

    // One ALIGN step: shift by min(SHIFT_PER_CYCLE, remaining), collecting guard/sticky
    logic [5:0]  amt;
    logic [5:0]  rem_d;
    logic [55:0] w_d;
    logic        guard_d;
    logic        sticky_d;

    always_comb begin
        amt      = (rem_q < SPC) ? rem_q : SPC;
        rem_d    = rem_q - amt;
        w_d      = w_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (6'(i) < amt) begin
                if (left_q) begin
                    w_d = {w_d[54:0], 1'b0};
                end else begin
                    sticky_d = sticky_d | guard_d;
                    guard_d  = w_d[0];
                    w_d      = {1'b0, w_d[55:1]};
                end
            end
        end
    end

    // ROUND datapath: optional RNE increment, range check, sign application
    logic        inc;
    logic [55:0] rnd_mag;
    logic        ovf;
    logic [31:0] rnd_res;

    always_comb begin
`ifdef FP2INT_RNE_EN
        inc = guard_q & (sticky_q | w_q[0]);
`else
        inc = 1'b0;
`endif
        rnd_mag = w_q + {55'd0, inc};
        ovf     = sign_q ? (rnd_mag > 56'h0000_0080_0000_00)
                         : (rnd_mag > 56'h0000_007F_FFFF_FF);
        rnd_res = sign_q ? (32'd0 - rnd_mag[31:0]) : rnd_mag[31:0];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            rem_q       <= '0;
            w_q         <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        left_q     <= (in_exp > 8'd150);
                        rem_q      <= in_n;
                        w_q        <= {32'd0, 1'b1, in_mant};
                        guard_q    <= 1'b0;
                        sticky_q   <= 1'b0;
                        in_ready_q <= 1'b0;
                        if (in_exp >= 8'd126 && in_exp <= 8'd158) begin
                            // finite with -1 <= e <= 31: needs alignment
                            state_q <= ALIGN;
                        end else begin
                            // special-case bypass straight to DONE
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            if (in_exp == 8'hFF && in_mant_nz) begin
                                out_data_q  <= POS_SAT;
                                out_flags_q <= 3'b100;
                            end else if (in_exp == 8'hFF || in_exp >= 8'd159) begin
                                out_data_q  <= in_sign ? NEG_SAT : POS_SAT;
                                out_flags_q <= 3'b010;
                            end else if (in_exp == 8'd0 && !in_mant_nz) begin
                                out_data_q  <= '0;
                                out_flags_q <= 3'b000;
                            end else begin
                                // denormal or |x| < 0.5: rounds to zero, inexact
                                out_data_q  <= '0;
                                out_flags_q <= 3'b001;
                            end
                        end
                    end
                end
                ALIGN: begin
                    w_q      <= w_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                    rem_q    <= rem_d;
                    // e == 23 enters with rem 0 and still spends this one cycle
                    if (rem_q <= SPC) state_q <= ROUND;
                end
                ROUND: begin
                    out_data_q  <= ovf ? (sign_q ? NEG_SAT : POS_SAT) : rnd_res;
                    out_flags_q <= {1'b0, ovf, (guard_q | sticky_q) & ~ovf};
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule
